// File: rtl/debug_uart_pkg.sv
// Shared types and constant helpers for the debug UART transmitter.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Bit period in clock cycles, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count and pointers; first word visible on rd_data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Buffered 8N1 UART transmitter for the debug byte stream.
// Define DEBUG_UART_HEX_EN to send each byte as two ASCII hex digits plus a space.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 48000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       uart_tx,
    output logic       busy
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
`ifdef DEBUG_UART_HEX_EN
    logic [7:0]       byte_q, byte_d;
    logic [1:0]       char_q, char_d;
`endif

    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic [CW-1:0]    fifo_count, fifo_count_nxt;
    logic             push_c, pop_c;

    assign in_ready = !fifo_full;
    assign push_c   = in_valid && !fifo_full;
    assign uart_tx  = tx_q;
    assign busy     = busy_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wr_data (in_data),
        .pop     (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencer: start bit, eight data bits LSB-first, stop bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
`ifdef DEBUG_UART_HEX_EN
        byte_d  = byte_q;
        char_d  = char_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    tx_d    = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
`ifdef DEBUG_UART_HEX_EN
                    if (char_q != 2'd2) begin
                        char_d  = char_q + 2'd1;
                        shift_d = (char_q == 2'd0) ? nib2ascii(byte_q[3:0]) : ASCII_SPACE;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else
`endif
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading a freshly popped byte into the shifter.
        if (pop_c) begin
`ifdef DEBUG_UART_HEX_EN
            byte_d  = fifo_rd_data;
            char_d  = 2'd0;
            shift_d = nib2ascii(fifo_rd_data[7:4]);
`else
            shift_d = fifo_rd_data;
`endif
        end

        fifo_count_nxt = fifo_count + CW'(push_c) - CW'(pop_c);
        busy_d = (state_d != ST_IDLE) || (fifo_count_nxt != '0);
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef DEBUG_UART_HEX_EN
            byte_q  <= '0;
            char_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef DEBUG_UART_HEX_EN
            byte_q  <= byte_d;
            char_q  <= char_d;
`endif
        end
    end

endmodule
